time_of_day: RTL

TIME_OF_DAY -- requirements
Module: time_of_day

---
 rtl/time_of_day.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/time_of_day.sv
// Time-of-day counter (hh:mm:ss) advanced by a one-second tick, with a validated load path.
// Optional daily alarm is enabled by defining TIME_OF_DAY_ALARM_EN.
module time_of_day #(
    parameter int HOURS = 24
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_load_valid,
    output logic       o_load_ready,
    input  logic [4:0] i_load_hh,
    input  logic [5:0] i_load_mm,
    input  logic [5:0] i_load_ss,
    output logic [4:0] o_hh,
    output logic [5:0] o_mm,
    output logic [5:0] o_ss,
    output logic       o_min_pulse,
    output logic       o_day_wrap,
    output logic       o_load_err
`ifdef TIME_OF_DAY_ALARM_EN
    ,
    input  logic       i_alarm_set,
    input  logic [4:0] i_alarm_hh,
    input  logic [5:0] i_alarm_mm,
    output logic       o_alarm
`endif
);

    localparam logic [4:0] HH_LIM = 5'(HOURS);
    localparam logic [4:0] HH_MAX = 5'(HOURS - 1);

    typedef enum logic {S_IDLE, S_APPLY} state_t;

    state_t     r_state;
    logic       r_load_ready;
    logic [4:0] r_hold_hh;
    logic [5:0] r_hold_mm;
    logic [5:0] r_hold_ss;
    logic [4:0] r_hh;
    logic [5:0] r_mm;
    logic [5:0] r_ss;
    logic       r_min_pulse;
    logic       r_day_wrap;
    logic       r_load_err;

    logic       w_accept;
    logic       w_do_tick;
    logic       w_hold_ok;
    logic       w_ss_wrap;
    logic       w_mm_wrap;
    logic       w_hh_wrap;
    logic [4:0] w_hh_next;
    logic [5:0] w_mm_next;
    logic [5:0] w_ss_next;

    assign w_accept  = i_load_valid && r_load_ready;
    assign w_do_tick = i_tick && (r_state == S_IDLE) && !w_accept;
    assign w_hold_ok = (r_hold_hh < HH_LIM) && (r_hold_mm <= 6'd59) && (r_hold_ss <= 6'd59);

    // Whole carry chain resolves in one cycle.
    assign w_ss_wrap = (r_ss == 6'd59);
    assign w_mm_wrap = (r_mm == 6'd59);
    assign w_hh_wrap = (r_hh == HH_MAX);
    assign w_ss_next = w_ss_wrap ? 6'd0 : r_ss + 6'd1;
    assign w_mm_next = w_ss_wrap ? (w_mm_wrap ? 6'd0 : r_mm + 6'd1) : r_mm;
    assign w_hh_next = (w_ss_wrap && w_mm_wrap) ? (w_hh_wrap ? 5'd0 : r_hh + 5'd1) : r_hh;

`ifdef TIME_OF_DAY_ALARM_EN
    logic       r_alarm_armed;
    logic [4:0] r_alarm_hh;
    logic [5:0] r_alarm_mm;
    logic       r_alarm;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_alarm_armed <= 1'b0;
            r_alarm_hh    <= 5'd0;
            r_alarm_mm    <= 6'd0;
            r_alarm       <= 1'b0;
        end else begin
            if (i_alarm_set) begin
                r_alarm_armed <= 1'b1;
                r_alarm_hh    <= i_alarm_hh;
                r_alarm_mm    <= i_alarm_mm;
            end
            // Only tick-driven arrivals at hh:mm:00 ring; loads never do.
            r_alarm <= w_do_tick && r_alarm_armed && w_ss_wrap &&
                       (w_mm_next == r_alarm_mm) && (w_hh_next == r_alarm_hh);
        end
    end

    assign o_alarm = r_alarm;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_load_ready <= 1'b0;
            r_hold_hh    <= 5'd0;
            r_hold_mm    <= 6'd0;
            r_hold_ss    <= 6'd0;
            r_hh         <= 5'd0;
            r_mm         <= 6'd0;
            r_ss         <= 6'd0;
            r_min_pulse  <= 1'b0;
            r_day_wrap   <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            r_min_pulse <= 1'b0;
            r_day_wrap  <= 1'b0;
            r_load_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_hold_hh    <= i_load_hh;
                        r_hold_mm    <= i_load_mm;
                        r_hold_ss    <= i_load_ss;
                        r_state      <= S_APPLY;
                        r_load_ready <= 1'b0;
                    end else begin
                        r_load_ready <= 1'b1;
                        if (w_do_tick) begin
                            r_ss        <= w_ss_next;
                            r_mm        <= w_mm_next;
                            r_hh        <= w_hh_next;
                            r_min_pulse <= w_ss_wrap;
                            r_day_wrap  <= w_ss_wrap && w_mm_wrap && w_hh_wrap;
                        end
                    end
                end
                S_APPLY: begin
                    r_state      <= S_IDLE;
                    r_load_ready <= 1'b1;
                    if (w_hold_ok) begin
                        r_hh <= r_hold_hh;
                        r_mm <= r_hold_mm;
                        r_ss <= r_hold_ss;
                    end else begin
                        r_load_err <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_load_ready <= 1'b0;
                end
            endcase
        end
    end

    assign o_load_ready = r_load_ready;
    assign o_hh         = r_hh;
    assign o_mm         = r_mm;
    assign o_ss         = r_ss;
    assign o_min_pulse  = r_min_pulse;
    assign o_day_wrap   = r_day_wrap;
    assign o_load_err   = r_load_err;

endmodule
